zap_wb_mem_arbiter: RTL

Two-master Wishbone arbiter sharing the core's single external memory port between the TLB page-walk FSM and the cache line-fill/write-back FSM. Grant is registered and held for the full Wishbone cycle (`cyc` high), so a burst is never interleaved. There is one dead bus cycle between grants. Arbitration is either fixed-priority (walker first) or round-robin, selected by a parameter. Only the granted master sees `ack` and read data.

---
 rtl/zap_wb_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/zap_wb_mem_arbiter.sv
// Two-master Wishbone arbiter: the TLB page walker (master 0) and the cache
// line-fill/write-back FSM (master 1) share one external memory port.
// A grant is held for the whole Wishbone cycle and every grant is separated
// from the next by one idle bus cycle. Bus signals are muxed straight from
// the granted master; only the grant state is registered.
module zap_wb_mem_arbiter #(
    parameter int WALK_PRIORITY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // Walker (master 0)
    input  logic        i_w_wb_cyc,
    input  logic        i_w_wb_stb,
    input  logic        i_w_wb_wen,
    input  logic [3:0]  i_w_wb_sel,
    input  logic [31:0] i_w_wb_adr,
    input  logic [31:0] i_w_wb_dat,
    output logic        o_w_wb_ack,
    output logic [31:0] o_w_wb_dat,
    // Cache FSM (master 1)
    input  logic        i_c_wb_cyc,
    input  logic        i_c_wb_stb,
    input  logic        i_c_wb_wen,
    input  logic [3:0]  i_c_wb_sel,
    input  logic [31:0] i_c_wb_adr,
    input  logic [31:0] i_c_wb_dat,
    output logic        o_c_wb_ack,
    output logic [31:0] o_c_wb_dat,
    // External bus
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    // One-hot grant: bit 0 walker, bit 1 cache
    output logic [1:0]  o_gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_W = 2'd1,
        GNT_C = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   last_r;       // last granted master, 0 = walker
    logic   last_nxt_s;
    logic   tie_to_w_s;   // on a tie, does the walker win?

    // Walker wins ties in priority mode; in round-robin mode the master that
    // was not served last wins.
    assign tie_to_w_s = (WALK_PRIORITY != 0) || (last_r == 1'b1);

    // Grant state and last-granted master register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= IDLE;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state: arbitrate only from IDLE, release when the owner drops cyc.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (i_w_wb_cyc && i_c_wb_cyc) begin
                    if (tie_to_w_s) begin
                        state_nxt_s = GNT_W;
                        last_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = GNT_C;
                        last_nxt_s  = 1'b1;
                    end
                end else if (i_w_wb_cyc) begin
                    state_nxt_s = GNT_W;
                    last_nxt_s  = 1'b0;
                end else if (i_c_wb_cyc) begin
                    state_nxt_s = GNT_C;
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT_W: begin
                if (i_w_wb_cyc) begin
                    state_nxt_s = GNT_W;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT_C: begin
                if (i_c_wb_cyc) begin
                    state_nxt_s = GNT_C;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                last_nxt_s  = 1'b0;
            end
        endcase
    end

    // Bus mux and response routing; everything is zero while idle, so a
    // stray ack in IDLE reaches nobody.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_wen   = 1'b0;
        o_wb_sel   = 4'h0;
        o_wb_adr   = 32'h0000_0000;
        o_wb_dat   = 32'h0000_0000;
        o_w_wb_ack = 1'b0;
        o_w_wb_dat = 32'h0000_0000;
        o_c_wb_ack = 1'b0;
        o_c_wb_dat = 32'h0000_0000;
        o_gnt      = 2'b00;
        case (state_r)
            GNT_W: begin
                o_wb_cyc   = i_w_wb_cyc;
                o_wb_stb   = i_w_wb_stb;
                o_wb_wen   = i_w_wb_wen;
                o_wb_sel   = i_w_wb_sel;
                o_wb_adr   = i_w_wb_adr;
                o_wb_dat   = i_w_wb_dat;
                o_w_wb_ack = i_wb_ack & i_w_wb_stb;
                o_w_wb_dat = i_wb_dat;
                o_gnt      = 2'b01;
            end
            GNT_C: begin
                o_wb_cyc   = i_c_wb_cyc;
                o_wb_stb   = i_c_wb_stb;
                o_wb_wen   = i_c_wb_wen;
                o_wb_sel   = i_c_wb_sel;
                o_wb_adr   = i_c_wb_adr;
                o_wb_dat   = i_c_wb_dat;
                o_c_wb_ack = i_wb_ack & i_c_wb_stb;
                o_c_wb_dat = i_wb_dat;
                o_gnt      = 2'b10;
            end
            IDLE: begin
                o_gnt = 2'b00;
            end
            default: begin
                o_gnt = 2'b00;
            end
        endcase
    end

endmodule
